// File: rtl/ascon_op_sequencer.sv
// ascon_op_sequencer
//
// Control front end for the Ascon core. Holds the three 128-bit operand
// registers, arbitrates writes to them between the SPI host (IDLE only) and
// the core writeback port (RUN only), launches the core with a one-cycle
// ready pulse, and supervises completion with a watchdog.
//
// Ports
//   clk, rst_n                   clock, asynchronous active-low reset
//   cmd_valid, cmd_mode[2:0]     host command request and operation mode (1..5)
//   cmd_ready                    high while a command can be accepted (IDLE)
//   host_wr_en/_sel/_data        host register write port
//   host_wr_blocked              one-cycle pulse after a dropped host write
//   reg0/1/2_128b                operand registers to the core
//   core_mode, core_ready        operation_mode / operation_ready to the core
//   core_wrback_en/_sel/_val     core writeback port
//   core_done                    core operation_done
//   busy                         high in LAUNCH, RUN and COMPLETE
//   done_irq                     one-cycle completion pulse
//   status[1:0]                  sticky: 00 ok, 01 timeout, 10 rejected command
module ascon_op_sequencer #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CTR_W          = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cmd_valid,
  input  logic [2:0]   cmd_mode,
  output logic         cmd_ready,
  input  logic         host_wr_en,
  input  logic [1:0]   host_wr_sel,
  input  logic [127:0] host_wr_data,
  output logic         host_wr_blocked,
  output logic [127:0] reg0_128b,
  output logic [127:0] reg1_128b,
  output logic [127:0] reg2_128b,
  output logic [2:0]   core_mode,
  output logic         core_ready,
  input  logic         core_wrback_en,
  input  logic [1:0]   core_wrback_sel,
  input  logic [127:0] core_wrback_val,
  input  logic         core_done,
  output logic         busy,
  output logic         done_irq,
  output logic [1:0]   status
);

  typedef enum logic [1:0] {IDLE, LAUNCH, RUN, COMPLETE} state_t;

  localparam logic [1:0]       STATUS_OK      = 2'b00;
  localparam logic [1:0]       STATUS_TIMEOUT = 2'b01;
  localparam logic [1:0]       STATUS_REJECT  = 2'b10;
  localparam logic [CTR_W-1:0] WDOG_LAST      = CTR_W'(TIMEOUT_CYCLES - 1);

  state_t             state_q, state_d;
  logic [127:0]       reg0_q, reg0_d;
  logic [127:0]       reg1_q, reg1_d;
  logic [127:0]       reg2_q, reg2_d;
  logic [2:0]         mode_q, mode_d;
  logic [1:0]         status_q, status_d;
  logic [CTR_W-1:0]   wdog_q, wdog_d;
  logic               blocked_q, blocked_d;
  logic               host_wr_ok;
  logic               core_wr_ok;

  function automatic logic mode_is_valid(input logic [2:0] m);
    return (m >= 3'd1) && (m <= 3'd5);
  endfunction

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    status_d = status_q;
    wdog_d   = wdog_q;
    reg0_d   = reg0_q;
    reg1_d   = reg1_q;
    reg2_d   = reg2_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          if (mode_is_valid(cmd_mode)) begin
            mode_d   = cmd_mode;
            status_d = STATUS_OK;
            state_d  = LAUNCH;
          end else begin
            status_d = STATUS_REJECT;
          end
        end
      end
      LAUNCH: begin
        wdog_d  = '0;
        state_d = RUN;
      end
      RUN: begin
        wdog_d = wdog_q + CTR_W'(1);
        // core_done is tested first so it wins over a coincident timeout
        if (core_done) begin
          state_d = COMPLETE;
        end else if (wdog_q == WDOG_LAST) begin
          status_d = STATUS_TIMEOUT;
          state_d  = COMPLETE;
        end
      end
      COMPLETE: begin
        mode_d  = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Host and core writers are separated by state, so they never collide.
    host_wr_ok = host_wr_en && (state_q == IDLE) && (host_wr_sel != 2'd3);
    core_wr_ok = core_wrback_en && (state_q == RUN) && (core_wrback_sel != 2'd3);

    if (host_wr_ok) begin
      case (host_wr_sel)
        2'd0:    reg0_d = host_wr_data;
        2'd1:    reg1_d = host_wr_data;
        default: reg2_d = host_wr_data;
      endcase
    end

    // Still honoured in the core_done cycle so the final tag lands.
    if (core_wr_ok) begin
      case (core_wrback_sel)
        2'd0:    reg0_d = core_wrback_val;
        2'd1:    reg1_d = core_wrback_val;
        default: reg2_d = core_wrback_val;
      endcase
    end

    blocked_d = host_wr_en && !host_wr_ok;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      reg0_q    <= '0;
      reg1_q    <= '0;
      reg2_q    <= '0;
      mode_q    <= '0;
      status_q  <= STATUS_OK;
      wdog_q    <= '0;
      blocked_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      reg0_q    <= reg0_d;
      reg1_q    <= reg1_d;
      reg2_q    <= reg2_d;
      mode_q    <= mode_d;
      status_q  <= status_d;
      wdog_q    <= wdog_d;
      blocked_q <= blocked_d;
    end
  end

  assign cmd_ready       = (state_q == IDLE);
  assign busy            = (state_q != IDLE);
  assign core_ready      = (state_q == LAUNCH);
  assign done_irq        = (state_q == COMPLETE);
  assign core_mode       = mode_q;
  assign status          = status_q;
  assign host_wr_blocked = blocked_q;
  assign reg0_128b       = reg0_q;
  assign reg1_128b       = reg1_q;
  assign reg2_128b       = reg2_q;

endmodule
